// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock through a
// single full_adder_2ha cell with a carry flip-flop between bits.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   -> adds port i_sub; i_sub=1 computes A-B (B inverted, carry-in 1)
//   undefined -> add-only, initial carry 0
//
// Also contains the full_adder_2ha cell (two half adders plus an OR) and the
// half-adder it is built from, so this file is self-contained.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module full_adder_2ha (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (s1),
        .o_carry (c1)
    );

    half_adder u_ha1 (
        .i_a     (s1),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (c2)
    );

    assign o_cout = c1 | c2;
endmodule

// State table
//   state   | meaning
//   IDLE    | waiting; a start loads operands and enters RUN
//   RUN     | one bit per cycle; counter runs 0..WIDTH-1
//   DONE    | single cycle; result presented, o_done high; start accepted
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             start_sub;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q, sub_d;

    assign start_sub = i_sub;
    // Subtract invert B's current bit; the +1 comes from the preset carry.
    assign fa_b      = b_q[0] ^ sub_q;

    // Operation mode is latched with the operands and held for the whole RUN.
    always_comb begin
        sub_d = sub_q;
        if (i_start && (state_q != ST_RUN)) begin
            sub_d = i_sub;
        end
    end

    // Mode register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`else
    assign start_sub = 1'b0;
    assign fa_b      = b_q[0];
`endif

    full_adder_2ha u_fa (
        .i_a    (a_q[0]),
        .i_b    (fa_b),
        .i_cin  (carry_q),
        .o_sum  (fa_sum),
        .o_cout (fa_cout)
    );

    // Next-state and datapath: load on accepted start, shift one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    a_d     = i_a;
                    b_d     = i_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = start_sub;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // i_start is deliberately not looked at here: RUN cannot be restarted.
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed word including this bit.
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift registers, carry and held result.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign o_busy = (state_q == ST_RUN);
    assign o_done = (state_q == ST_DONE);
    assign o_sum  = sum_q;
    assign o_cout = cout_q;

endmodule
